// File: rtl/iex_router_pkg.sv
// Shared constants, slot state encoding and power-on routing table for the IEX display router.
package iex_router_pkg;

    localparam int DEF_USER_W = 3;
    localparam int DEF_N_IF   = 2;
    localparam int DEF_HOLD   = 8;
    localparam int TMR_W      = 8;

    localparam int IS1 = 0;
    localparam int IS2 = 1;

    typedef enum logic {
        SLOT_IDLE = 1'b0,
        SLOT_SHOW = 1'b1
    } slot_state_e;

    // Users 3 and 5 are shown on IS1; everyone else goes to IS2.
    function automatic int default_if(input int user);
        return ((user == 3) || (user == 5)) ? IS1 : IS2;
    endfunction

endpackage

// File: rtl/iex_if_slot.sv
// One output interface: IDLE/SHOW state machine with a hold timer and early release.
module iex_if_slot
    import iex_router_pkg::*;
#(
    parameter int USER_W = DEF_USER_W,
    parameter int HOLD   = DEF_HOLD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [USER_W-1:0] load_user,
    input  logic              ack,
    output logic              idle,
    output logic              active,
    output logic              start,
    output logic [USER_W-1:0] user
);

    slot_state_e       state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [USER_W-1:0] user_q, user_d;
    logic              start_q, start_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SLOT_IDLE;
            timer_q <= '0;
            user_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            user_q  <= user_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        user_d  = user_q;
        start_d = 1'b0;
        case (state_q)
            SLOT_IDLE: begin
                if (load) begin
                    state_d = SLOT_SHOW;
                    timer_d = TMR_W'(HOLD - 1);
                    user_d  = load_user;
                    start_d = 1'b1;
                end
            end
            SLOT_SHOW: begin
                // Timer reaching zero and an early ack both end the display at the next edge.
                if ((timer_q == '0) || ack) begin
                    state_d = SLOT_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = SLOT_IDLE;
        endcase
    end

    assign idle   = (state_q == SLOT_IDLE);
    assign active = (state_q == SLOT_SHOW);
    assign start  = start_q;
    assign user   = user_q;

endmodule

// File: rtl/iex_router.sv
// Routes display requests to one of N_IF interfaces via a writable user->interface table.
module iex_router
    import iex_router_pkg::*;
#(
    parameter int USER_W = DEF_USER_W,
    parameter int N_IF   = DEF_N_IF,
    parameter int IF_W   = 1,
    parameter int HOLD   = DEF_HOLD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [USER_W-1:0]        req_user,
    output logic                     req_ready,
    output logic [IF_W-1:0]          req_if,
    input  logic                     cfg_we,
    input  logic [USER_W-1:0]        cfg_user,
    input  logic [IF_W-1:0]          cfg_if,
    input  logic [N_IF-1:0]          if_ack,
    output logic [N_IF-1:0]          if_active,
    output logic [N_IF*USER_W-1:0]   if_user,
    output logic [N_IF-1:0]          if_start
);

    localparam int TBL_N = 1 << USER_W;

    logic [IF_W-1:0] table_q [TBL_N];
    logic [IF_W-1:0] table_d [TBL_N];
    logic [N_IF-1:0] slot_idle;
    logic [N_IF-1:0] slot_load;
    logic            target_idle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TBL_N; i++) begin
                table_q[i] <= IF_W'(default_if(i));
            end
        end else begin
            table_q <= table_d;
        end
    end

    // The request decode reads table_q, so a same-cycle write only affects later requests.
    always_comb begin
        table_d = table_q;
        if (cfg_we) begin
            table_d[cfg_user] = cfg_if;
        end
    end

    assign req_if = table_q[req_user];

    // An entry pointing past the last interface matches no slot and so is never ready.
    always_comb begin
        target_idle = 1'b0;
        for (int k = 0; k < N_IF; k++) begin
            if (req_if == IF_W'(k)) begin
                target_idle = slot_idle[k];
            end
        end
    end

    assign req_ready = ~reset & target_idle;

    always_comb begin
        slot_load = '0;
        for (int k = 0; k < N_IF; k++) begin
            slot_load[k] = req_valid & req_ready & (req_if == IF_W'(k));
        end
    end

    for (genvar k = 0; k < N_IF; k++) begin : g_slot
        iex_if_slot #(
            .USER_W (USER_W),
            .HOLD   (HOLD)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (slot_load[k]),
            .load_user (req_user),
            .ack       (if_ack[k]),
            .idle      (slot_idle[k]),
            .active    (if_active[k]),
            .start     (if_start[k]),
            .user      (if_user[k*USER_W +: USER_W])
        );
    end

endmodule

// File: tb/tb_iex_router.sv
// Directed bench for iex_router: default 2-interface build plus a 3-interface HOLD=1 build.
module tb_iex_router;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Default build: USER_W=3, N_IF=2, IF_W=1, HOLD=8
    logic       a_req_valid, a_req_ready, a_req_if, a_cfg_we, a_cfg_if;
    logic [2:0] a_req_user, a_cfg_user;
    logic [1:0] a_if_ack, a_if_active, a_if_start;
    logic [5:0] a_if_user;

    // Wide build: USER_W=4, N_IF=3, IF_W=2, HOLD=1
    logic       b_req_valid, b_req_ready, b_cfg_we;
    logic [3:0] b_req_user, b_cfg_user;
    logic [1:0] b_req_if, b_cfg_if;
    logic [2:0] b_if_ack, b_if_active, b_if_start;
    logic [11:0] b_if_user;

    int tests_run = 0;
    int tests_failed = 0;

    iex_router u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_user(a_req_user), .req_ready(a_req_ready), .req_if(a_req_if),
        .cfg_we(a_cfg_we), .cfg_user(a_cfg_user), .cfg_if(a_cfg_if),
        .if_ack(a_if_ack), .if_active(a_if_active), .if_user(a_if_user), .if_start(a_if_start)
    );

    iex_router #(.USER_W(4), .N_IF(3), .IF_W(2), .HOLD(1)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_user(b_req_user), .req_ready(b_req_ready), .req_if(b_req_if),
        .cfg_we(b_cfg_we), .cfg_user(b_cfg_user), .cfg_if(b_cfg_if),
        .if_ack(b_if_ack), .if_active(b_if_active), .if_user(b_if_user), .if_start(b_if_start)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        a_req_valid = 1'b1; a_req_user = 3'd3; a_cfg_we = 1'b0; a_cfg_user = '0; a_cfg_if = 1'b0; a_if_ack = '0;
        b_req_valid = 1'b0; b_req_user = '0;   b_cfg_we = 1'b0; b_cfg_user = '0; b_cfg_if = '0;   b_if_ack = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", a_req_ready, 1'b0);
        chk("rst_active", a_if_active, 2'b00);
        chk("rst_start", a_if_start, 2'b00);
        chk("rst_user", a_if_user, 6'd0);
        chk("rst_b_active", b_if_active, 3'b000);
        reset = 1'b0;
        #1;

        // Basic request: user 3 -> IS1, 8 active cycles
        chk("u3_req_if", a_req_if, 1'b0);
        chk("u3_ready", a_req_ready, 1'b1);
        step();
        a_req_valid = 1'b0;
        chk("u3_start", a_if_start, 2'b01);
        chk("u3_active", a_if_active, 2'b01);
        chk("u3_user0", a_if_user[2:0], 3'd3);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("u3_hold_active", a_if_active[0], 1'b1);
        end
        chk("u3_start_once", a_if_start, 2'b00);
        step();
        chk("u3_expire", a_if_active, 2'b00);
        chk("u3_user_kept", a_if_user[2:0], 3'd3);

        // IS2 busy with user 2; user 6 must wait until it drains
        a_req_valid = 1'b1; a_req_user = 3'd2;
        #1;
        chk("u2_req_if", a_req_if, 1'b1);
        chk("u2_ready", a_req_ready, 1'b1);
        step();
        chk("u2_start", a_if_start, 2'b10);
        a_req_user = 3'd6;
        #1;
        n = 0;
        while (a_if_active[1] && n < 20) begin
            chk("u6_blocked", a_req_ready, 1'b0);
            step();
            n++;
        end
        chk("u6_wait_cycles", n, 8);
        chk("u6_ready_after", a_req_ready, 1'b1);
        step();
        a_req_valid = 1'b0;
        chk("u6_start", a_if_start, 2'b10);
        chk("u6_user1", a_if_user[5:3], 3'd6);
        repeat (8) step();
        chk("u6_expire", a_if_active, 2'b00);

        // Same-cycle table write routes with the old entry
        a_cfg_we = 1'b1; a_cfg_user = 3'd2; a_cfg_if = 1'b0;
        a_req_valid = 1'b1; a_req_user = 3'd2;
        #1;
        chk("cfg_old_if", a_req_if, 1'b1);
        step();
        a_cfg_we = 1'b0;
        chk("cfg_old_start", a_if_start, 2'b10);
        #1;
        chk("cfg_new_if", a_req_if, 1'b0);
        chk("cfg_new_ready", a_req_ready, 1'b1);
        step();
        a_req_valid = 1'b0;
        chk("cfg_new_start", a_if_start, 2'b01);
        chk("cfg_new_user0", a_if_user[2:0], 3'd2);
        chk("cfg_both_active", a_if_active, 2'b11);
        repeat (8) step();
        chk("cfg_expire", a_if_active, 2'b00);

        // Early ack on cycle 3 of SHOW; ack to an idle interface is ignored
        a_req_valid = 1'b1; a_req_user = 3'd3;
        step();
        a_req_valid = 1'b0;
        step();
        step();
        a_if_ack = 2'b01;
        step();
        a_if_ack = 2'b00;
        chk("ack_release", a_if_active[0], 1'b0);
        a_req_user = 3'd3;
        #1;
        chk("ack_rearm_ready", a_req_ready, 1'b1);
        a_if_ack = 2'b10;
        step();
        a_if_ack = 2'b00;
        chk("ack_idle_active", a_if_active, 2'b00);
        chk("ack_idle_start", a_if_start, 2'b00);
        a_req_user = 3'd6;
        #1;
        chk("ack_idle_ready", a_req_ready, 1'b1);

        // Reset mid-SHOW on both interfaces restores the table
        a_req_valid = 1'b1; a_req_user = 3'd3;
        step();
        a_req_user = 3'd6;
        step();
        a_req_valid = 1'b0;
        a_cfg_we = 1'b1; a_cfg_user = 3'd5; a_cfg_if = 1'b1;
        step();
        a_cfg_we = 1'b0;
        chk("pre_rst_active", a_if_active, 2'b11);
        a_req_user = 3'd5;
        #1;
        chk("pre_rst_u5_if", a_req_if, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_active", a_if_active, 2'b00);
        chk("mid_rst_start", a_if_start, 2'b00);
        chk("mid_rst_user", a_if_user, 6'd0);
        chk("mid_rst_ready", a_req_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk("post_rst_u5_if", a_req_if, 1'b0);
        a_req_user = 3'd2;
        #1;
        chk("post_rst_u2_if", a_req_if, 1'b1);
        step();
        chk("post_rst_no_residual", a_if_active, 2'b00);

        // Wide build: three interfaces, HOLD=1, out-of-range entry
        b_cfg_we = 1'b1; b_cfg_user = 4'd7; b_cfg_if = 2'd2;
        step();
        b_cfg_user = 4'd9; b_cfg_if = 2'd3;
        step();
        b_cfg_we = 1'b0;
        b_req_valid = 1'b1; b_req_user = 4'd3;
        #1;
        chk("b_u3_ready", b_req_ready, 1'b1);
        step();
        chk("b_u3_start", b_if_start, 3'b001);
        chk("b_u3_active", b_if_active, 3'b001);
        b_req_user = 4'd1;
        #1;
        chk("b_u1_if", b_req_if, 2'd1);
        chk("b_u1_ready", b_req_ready, 1'b1);
        step();
        chk("b_u1_active", b_if_active, 3'b010);
        b_req_user = 4'd7;
        #1;
        chk("b_u7_if", b_req_if, 2'd2);
        chk("b_u7_ready", b_req_ready, 1'b1);
        step();
        chk("b_u7_active", b_if_active, 3'b100);
        chk("b_u7_user2", b_if_user[11:8], 4'd7);
        b_req_user = 4'd9;
        #1;
        chk("b_u9_if", b_req_if, 2'd3);
        chk("b_u9_ready", b_req_ready, 1'b0);
        step();
        b_req_valid = 1'b0;
        chk("b_u9_active", b_if_active, 3'b000);
        chk("b_u9_start", b_if_start, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/iex_router.md
IEX_ROUTER -- requirements
Module: iex_router

Interface
REQ-001 Parameter USER_W, default 3, user code width.
REQ-002 Parameter N_IF, default 2, number of output interfaces; index 0 = IS1, index 1 = IS2.
REQ-003 Parameter IF_W, default 1, interface index width; SHALL equal ceil(log2(N_IF)), minimum 1.
REQ-004 Parameter HOLD, default 8, display hold time in cycles; range 1..255.
REQ-005 clk  input  1  single clock; all state rising-edge.
REQ-006 reset  input  1  asynchronous, active-high.
REQ-007 req_valid  input  1  display request present.
REQ-008 req_user  input  USER_W  requesting user code.
REQ-009 req_ready  output  1  request accepted this cycle when req_valid=1.
REQ-010 req_if  output  IF_W  interface the current req_user maps to; combinational.
REQ-011 cfg_we  input  1  routing-table write strobe.
REQ-012 cfg_user  input  USER_W  table entry to write.
REQ-013 cfg_if  input  IF_W  interface value to write.
REQ-014 if_ack  input  N_IF  per-interface early release, one bit per interface.
REQ-015 if_active  output  N_IF  interface currently displaying.
REQ-016 if_user  output  N_IF*USER_W  user shown on each interface; slice k belongs to interface k.
REQ-017 if_start  output  N_IF  one-cycle pulse when a display begins.

Function
REQ-018 Routing table: 2^USER_W entries of IF_W bits; req_if SHALL equal table[req_user].
REQ-019 Default table after reset: users 3 and 5 map to 0 (IS1); all other users map to 1 (IS2).
REQ-020 Each interface SHALL run its own FSM with states IDLE and SHOW.
REQ-021 req_ready SHALL be 1 iff the interface table[req_user] is in IDLE and table[req_user] < N_IF; it is combinational.
REQ-022 On req_valid & req_ready, at the next edge the target interface SHALL enter SHOW, load if_user with req_user, load its timer with HOLD-1, and pulse if_start for exactly one cycle.
REQ-023 In SHOW, the timer SHALL decrement by one each cycle. When the timer is 0, or when if_ack[k]=1, the interface SHALL return to IDLE at the next edge.
REQ-024 if_active[k] SHALL be 1 exactly while interface k is in SHOW. HOLD=1 therefore gives a single active cycle.
REQ-025 if_user[k] SHALL hold its last value in IDLE.
REQ-026 An if_ack to an interface already in IDLE SHALL be ignored.
REQ-027 A table entry that maps to an index >= N_IF SHALL never be accepted: req_ready=0, no state change.
REQ-028 cfg_we SHALL write table[cfg_user] at the edge.
REQ-029 When cfg_we and a request for the same user occur in the same cycle, the request SHALL route using the old entry.
REQ-030 A table write SHALL NOT affect an interface already in SHOW.
REQ-031 Back-to-back requests: an interface leaving SHOW at edge t SHALL NOT accept a request until the cycle after t (no same-edge re-arm). Requests mapped to other interfaces SHALL be unaffected.
REQ-032 At most one request SHALL be accepted per cycle.

Reset
REQ-033 On reset assertion, asynchronously: all FSMs to IDLE; timers 0; if_active=0; if_start=0; if_user=0; table to the REQ-019 default.
REQ-034 Reset asserted mid-SHOW SHALL abort the display immediately, with no if_start and no residual active cycle.
REQ-035 req_ready SHALL be 0 while reset is asserted.

Structure
REQ-036 A shared package SHALL hold: default USER_W/N_IF/HOLD, the IS1=0/IS2=1 index constants, the FSM state encoding, and the default-table function.
REQ-037 Sub-module iex_if_slot SHALL implement one interface FSM and timer; iex_router SHALL instantiate N_IF copies and hold the routing table and request decode.

Verification
REQ-038 Reset, then req_valid=1, req_user=3 -> req_if=0, req_ready=1; if_start[0] pulses; if_active[0]=1 for 8 cycles; if_user slice 0 = 3.
REQ-039 With interface 1 in SHOW for user 2, request user 6 -> req_ready=0 until if_active[1] falls; then accepted the following cycle.
REQ-040 cfg_we writing user 2 -> IS1 in the same cycle as a request for user 2 -> request goes to IS2; the next request for user 2 goes to IS1.
REQ-041 if_ack[0] pulsed on cycle 3 of SHOW -> if_active[0]=0 after the next edge; an if_ack to an IDLE interface has no effect.
REQ-042 Reset asserted mid-SHOW on both interfaces -> all outputs 0 immediately; the table is restored (user 5 -> 0, user 2 -> 1).
REQ-043 N_IF=3, USER_W=4, HOLD=1 build: requests to three distinct interfaces on consecutive cycles are each accepted with a one-cycle active; an entry set to 3 never asserts req_ready.
